// File: rtl/circ_conv_pkg.sv
// Shared types and helpers for the circular convolution/correlation engine.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, mode_t run mode, acc_w() accumulator width,
// sat_or_wrap() final QLEN reduction. Build option: CIRC_CONV_SAT_EN selects
// saturation; default build wraps.
package circ_conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        MODE_CORR = 1'b0,
        MODE_CONV = 1'b1
    } mode_t;

    // Each product keeps 2*QLEN-FRAC bits after the shift; N of them need
    // clog2(N) growth bits so the running sum can never overflow.
    function automatic int acc_w(input int qlen, input int frac, input int n);
        return 2 * qlen - frac + $clog2(n);
    endfunction

    // Reduce a sign-extended accumulator to QLEN bits. The caller keeps the
    // low QLEN bits of the returned value.
    function automatic logic signed [63:0] sat_or_wrap(input logic signed [63:0] acc,
                                                       input int qlen);
`ifdef CIRC_CONV_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (qlen - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (qlen - 1));
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end else begin
            return acc;
        end
`else
        logic signed [63:0] mask;
        mask = (64'sd1 <<< qlen) - 64'sd1;
        return acc & mask;
`endif
    endfunction

endpackage

// File: rtl/circ_conv_lane.sv
// One output lane: full N-term dot product of w against a rotated x.
// Latency: purely combinational; the parent registers sum_o.
// Backpressure: none, evaluated every cycle from held operands.
// Ports: x_i/w_i flat sample/weight vectors (element i at [i*QLEN +: QLEN]),
//        conv_i 1 = convolution index (k-j), 0 = correlation (j+k),
//        k_i output index, sum_o ACC_W-bit signed sum.
module circ_conv_lane
    import circ_conv_pkg::*;
#(
    parameter int QLEN        = 16,
    parameter int FRAC_SIZE   = 12,
    parameter int WINDOW_SIZE = 16,
    parameter int IDXW        = $clog2(WINDOW_SIZE),
    parameter int ACC_W       = acc_w(QLEN, FRAC_SIZE, WINDOW_SIZE)
) (
    input  logic [WINDOW_SIZE*QLEN-1:0] x_i,
    input  logic [WINDOW_SIZE*QLEN-1:0] w_i,
    input  logic                        conv_i,
    input  logic [IDXW-1:0]             k_i,
    output logic signed [ACC_W-1:0]     sum_o
);

    localparam int PW = 2 * QLEN - FRAC_SIZE;

    logic signed [QLEN-1:0]   xa [WINDOW_SIZE];
    logic signed [QLEN-1:0]   wa [WINDOW_SIZE];
    logic signed [ACC_W-1:0]  acc;
    logic signed [2*QLEN-1:0] prod;
    logic signed [PW-1:0]     term;
    logic [IDXW-1:0]          idx;
    int                       t;

    for (genvar i = 0; i < WINDOW_SIZE; i++) begin : g_unpack
        assign xa[i] = x_i[i*QLEN +: QLEN];
        assign wa[i] = w_i[i*QLEN +: QLEN];
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        term = '0;
        idx  = '0;
        t    = 0;
        for (int j = 0; j < WINDOW_SIZE; j++) begin
            // Both k and j are below N, so a single conditional correction
            // implements the modulo for any N, not just powers of two.
            if (conv_i) begin
                t = int'(k_i) - j;
                if (t < 0) t = t + WINDOW_SIZE;
            end else begin
                t = int'(k_i) + j;
                if (t >= WINDOW_SIZE) t = t - WINDOW_SIZE;
            end
            idx  = IDXW'(t);
            prod = wa[IDXW'(j)] * xa[idx];
            // Arithmetic shift floors toward -inf; the top FRAC bits are
            // pure sign copies and are dropped.
            term = PW'(prod >>> FRAC_SIZE);
            acc  = acc + ACC_W'(term);
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/circular_conv_engine.sv
// Fixed-point N-point circular correlation/convolution, LANES outputs per cycle.
// Latency: out_valid rises C+1 edges after accept (C = N/LANES); 1 window per C+3 cycles.
// Backpressure: result held while out_ready=0; in_ready only in IDLE, no run overlap.
// Ports: clk, rst (async, active-high); in_valid/in_ready with mode, weights,
//        in_data (flat N x QLEN, element i at [i*QLEN +: QLEN]); out_valid/out_ready
//        with out_data (same packing). Build option: CIRC_CONV_SAT_EN saturates
//        results to QLEN, otherwise the low QLEN bits are kept.
module circular_conv_engine
    import circ_conv_pkg::*;
#(
    parameter int QLEN        = 16,
    parameter int FRAC_SIZE   = 12,
    parameter int WINDOW_SIZE = 16,
    parameter int LANES       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        mode,
    input  logic [WINDOW_SIZE*QLEN-1:0] weights,
    input  logic [WINDOW_SIZE*QLEN-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WINDOW_SIZE*QLEN-1:0] out_data
);

    localparam int C     = WINDOW_SIZE / LANES;
    localparam int PTRW  = (C > 1) ? $clog2(C) : 1;
    localparam int IDXW  = $clog2(WINDOW_SIZE);
    localparam int ACC_W = acc_w(QLEN, FRAC_SIZE, WINDOW_SIZE);

    if (WINDOW_SIZE < 2) begin : g_bad_n
        $error("circular_conv_engine: WINDOW_SIZE must be >= 2");
    end
    if (WINDOW_SIZE % LANES != 0) begin : g_bad_lanes
        $error("circular_conv_engine: WINDOW_SIZE must be a multiple of LANES");
    end

    state_t                        state_q, state_d;
    logic [PTRW-1:0]               ptr_q, ptr_d;
    logic                          out_valid_q, out_valid_d;
    logic [WINDOW_SIZE*QLEN-1:0]   x_q, w_q;
    mode_t                         mode_q;
    logic                          wr_en_q;
    logic [PTRW-1:0]               wr_grp_q;
    logic signed [ACC_W-1:0]       lane_sum [LANES];
    logic signed [ACC_W-1:0]       sum_q    [LANES];
    logic                          accept;

    assign in_ready  = (state_q == IDLE);
    assign accept    = (state_q == IDLE) && in_valid;
    assign out_valid = out_valid_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = COMPUTE;
                    ptr_d   = '0;
                end
            end
            COMPUTE: begin
                if (ptr_q == PTRW'(C - 1)) begin
                    ptr_d   = '0;
                    state_d = DRAIN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last group lands in out_data on this edge, so valid rises with it.
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operands are frozen at accept so later input activity cannot disturb a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            w_q      <= '0;
            mode_q   <= MODE_CORR;
            wr_en_q  <= 1'b0;
            wr_grp_q <= '0;
            for (int l = 0; l < LANES; l++) sum_q[l] <= '0;
        end else begin
            if (accept) begin
                x_q    <= in_data;
                w_q    <= weights;
                mode_q <= mode_t'(mode);
            end
            wr_en_q  <= (state_q == COMPUTE);
            wr_grp_q <= ptr_q;
            if (state_q == COMPUTE) begin
                for (int l = 0; l < LANES; l++) sum_q[l] <= lane_sum[l];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDXW-1:0] lane_k;
        assign lane_k = IDXW'(int'(ptr_q) * LANES + l);

        circ_conv_lane #(
            .QLEN        (QLEN),
            .FRAC_SIZE   (FRAC_SIZE),
            .WINDOW_SIZE (WINDOW_SIZE),
            .IDXW        (IDXW),
            .ACC_W       (ACC_W)
        ) u_lane (
            .x_i    (x_q),
            .w_i    (w_q),
            .conv_i (mode_q == MODE_CONV),
            .k_i    (lane_k),
            .sum_o  (lane_sum[l])
        );
    end

    // Each output element is its own register, written only when its group
    // comes out of the sum pipeline register; otherwise it holds.
    for (genvar e = 0; e < WINDOW_SIZE; e++) begin : g_out
        localparam int GE = e / LANES;
        localparam int LE = e % LANES;
        logic [QLEN-1:0] y_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                y_q <= '0;
            end else if (wr_en_q && (wr_grp_q == PTRW'(GE))) begin
                y_q <= QLEN'(sat_or_wrap(64'(sum_q[LE]), QLEN));
            end
        end

        assign out_data[e*QLEN +: QLEN] = y_q;
    end

endmodule

// File: tb/tb_circular_conv_engine.sv
// Directed and randomised checks of circular_conv_engine with N=4, LANES=2, Q4.12.
// Latency: expects out_valid C+1 = 3 edges after accept.
// Backpressure: holds out_ready low to check output hold and input lockout.
module tb_circular_conv_engine;

    localparam int QLEN  = 16;
    localparam int FRAC  = 12;
    localparam int N     = 4;
    localparam int LANES = 2;
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mode = 1'b0;
    logic [63:0]   weights = '0;
    logic [63:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    circular_conv_engine #(
        .QLEN        (QLEN),
        .FRAC_SIZE   (FRAC),
        .WINDOW_SIZE (N),
        .LANES       (LANES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .weights   (weights),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Element 0 is the first argument (lowest bits).
    function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [63:0] ref_model(input logic [63:0] w, x, input logic md);
        logic [63:0] y;
        longint acc, p;
        logic [15:0] wj, xi;
        int idx;
        y = '0;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                idx = md ? ((k - j + N) % N) : ((j + k) % N);
                wj  = w[j*16 +: 16];
                xi  = x[idx*16 +: 16];
                p   = longint'($signed(wj)) * longint'($signed(xi));
                acc = acc + (p >>> FRAC);
            end
`ifdef CIRC_CONV_SAT_EN
            if (acc > 32767)       y[k*16 +: 16] = 16'h7FFF;
            else if (acc < -32768) y[k*16 +: 16] = 16'h8000;
            else                   y[k*16 +: 16] = acc[15:0];
`else
            y[k*16 +: 16] = acc[15:0];
`endif
        end
        return y;
    endfunction

    // Drives one window, perturbs inputs right after accept, waits (bounded)
    // for the result, then completes the output handshake after ready_dly cycles.
    task automatic run_window(input logic [63:0] w, x, input logic md,
                              input int ready_dly, input bit ready_early,
                              output logic [63:0] y, output int lat);
        int g;
        @(negedge clk);
        in_valid  = 1'b1;
        weights   = w;
        in_data   = x;
        mode      = md;
        out_ready = ready_early;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        weights  = ~w;
        in_data  = ~x;
        mode     = ~md;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        y = out_data;
        repeat (ready_dly) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [63:0] y, exp;
        int lat;
        exp = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        run_window(pk(16'h1000, 0, 0, 0), exp, 1'b0, 0, 1'b0, y, lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL identity_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL identity_data: got %h want %h", y, exp);
        end
    endtask

    task automatic test_rotation();
        logic [63:0] x, y, exp;
        int lat;
        x = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        run_window(pk(0, 16'h1000, 0, 0), x, 1'b0, 1, 1'b0, y, lat);
        exp = pk(16'h2000, 16'h3000, 16'h4000, 16'h1000);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL rotation_corr: got %h want %h", y, exp);
        end
        run_window(pk(0, 16'h1000, 0, 0), x, 1'b1, 0, 1'b0, y, lat);
        exp = pk(16'h4000, 16'h1000, 16'h2000, 16'h3000);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL rotation_conv: got %h want %h", y, exp);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL rotation_latency: got %0d want %0d", lat, LAT);
        end
    endtask

    // 0.5 times -1 lsb, 3 lsb, -8.0, max: exercises floor truncation of negatives.
    task automatic test_truncation();
        logic [63:0] y, exp;
        int lat;
        run_window(pk(16'h0800, 0, 0, 0), pk(16'hFFFF, 16'h0003, 16'h8000, 16'h7FFF),
                   1'b1, 0, 1'b0, y, lat);
        exp = pk(16'hFFFF, 16'h0001, 16'hC000, 16'h3FFF);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL truncation: got %h want %h", y, exp);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] y, exp_pos, exp_neg, all4;
        int lat;
        all4 = pk(16'h4000, 16'h4000, 16'h4000, 16'h4000);
`ifdef CIRC_CONV_SAT_EN
        exp_pos = 64'h7FFF_7FFF_7FFF_7FFF;
        exp_neg = 64'h8000_8000_8000_8000;
`else
        exp_pos = 64'h0;
        exp_neg = 64'h0;
`endif
        run_window(all4, all4, 1'b0, 0, 1'b0, y, lat);
        checks++;
        if (y !== exp_pos) begin
            errors++;
            $display("FAIL overflow_pos: got %h want %h", y, exp_pos);
        end
        run_window(pk(16'hC000, 16'hC000, 16'hC000, 16'hC000), all4, 1'b1, 0, 1'b0, y, lat);
        checks++;
        if (y !== exp_neg) begin
            errors++;
            $display("FAIL overflow_neg: got %h want %h", y, exp_neg);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp, x;
        int wt;
        x   = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        exp = pk(16'h2000, 16'h3000, 16'h4000, 16'h1000);
        @(negedge clk);
        in_valid = 1'b1;
        weights  = pk(0, 16'h1000, 0, 0);
        in_data  = x;
        mode     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wt = 0;
        while (!out_valid && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL bp_result: got %h want %h", out_data, exp);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            weights  = pk(16'h1000, 16'h1000, 16'h1000, 16'h1000);
            in_data  = ~x;
            mode     = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_valid_hold cycle %0d: got %b want 1", c, out_valid);
            end
            checks++;
            if (out_data !== exp) begin
                errors++;
                $display("FAIL bp_data_hold cycle %0d: got %h want %h", c, out_data, exp);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_valid_drop: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL bp_data_retain: got %h want %h", out_data, exp);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_return: got %b want 1", in_ready);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_ghost_run: got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] y, exp;
        int lat;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        weights  = pk(0, 16'h1000, 0, 0);
        in_data  = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        mode     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== 64'h0) begin
            errors++;
            $display("FAIL midrst_data: got %h want 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_partial_valid: got %b want 0", seen);
        end
        exp = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        run_window(pk(16'h1000, 0, 0, 0), exp, 1'b0, 0, 1'b0, y, lat);
        checks++;
        if (y !== exp || lat !== LAT) begin
            errors++;
            $display("FAIL midrst_rerun: got %h lat %0d want %h lat %0d", y, lat, exp, LAT);
        end
    endtask

    // in_valid and out_ready both held high: accepts must be C+3 cycles apart.
    task automatic test_back_to_back();
        logic [63:0] x, exp;
        int first, second, wt;
        x = pk(16'h1000, 16'h2000, 16'h3000, 16'h4000);
        first  = -1;
        second = -1;
        @(negedge clk);
        in_valid  = 1'b1;
        weights   = pk(16'h1000, 0, 0, 0);
        in_data   = x;
        mode      = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && second < 0; c++) begin
            if (in_ready) begin
                if (first < 0) first = c;
                else second = c;
            end
            if (second < 0) begin
                @(negedge clk);
                if (first >= 0) weights = pk(0, 16'h1000, 0, 0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (second - first !== LAT + 2 || first < 0 || second < 0) begin
            errors++;
            $display("FAIL b2b_period: got %0d want %0d", second - first, LAT + 2);
        end
        wt = 0;
        while (!out_valid && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        exp = pk(16'h2000, 16'h3000, 16'h4000, 16'h1000);
        checks++;
        if (out_data !== exp || wt !== LAT) begin
            errors++;
            $display("FAIL b2b_second_result: got %h lat %0d want %h lat %0d",
                     out_data, wt, exp, LAT);
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] w, x, y, exp;
        logic md;
        int lat;
        for (int n = 0; n < 40; n++) begin
            w  = {$urandom(), $urandom()};
            x  = {$urandom(), $urandom()};
            if (n % 3 == 0) w = w >>> 3;
            md = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exp = ref_model(w, x, md);
            run_window(w, x, md, $urandom_range(0, 3), bit'($urandom_range(0, 1)), y, lat);
            checks++;
            if (y !== exp || lat !== LAT) begin
                errors++;
                $display("FAIL random_%0d mode %b: got %h lat %0d want %h lat %0d",
                         n, md, y, lat, exp, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotation();
        test_truncation();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
